// File: rtl/pc_gen_btb_if.sv
// rtl/pc_gen_btb_if.sv - fetch-PC generator bundle: stall/redirect/training inputs, PC/prediction outputs
//
// Purpose: groups every non-clock/reset signal of pc_gen_btb.
// Ports (signals):
//   stall, redirect_valid, redirect_pc          pipeline control into the PC generator
//   upd_valid, upd_pc, upd_target, upd_taken    BTB training from EX
//   pc, pc4, npc, pred_taken, pred_target       fetch PC and prediction out of the generator
// Modports: master drives the control/training side, slave is the PC generator.
interface pc_gen_btb_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] npc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  pc, pc4, npc, pred_taken, pred_target
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output pc, pc4, npc, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_gen_btb.sv
// rtl/pc_gen_btb.sv - next-PC generator with direct-mapped BTB and 2-bit counters
//
// Purpose: holds the fetch PC, applies redirect/stall, and predicts taken
// control flow at fetch using a direct-mapped branch target buffer.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset
//   bus   slave modport of pc_gen_btb_if:
//         stall, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target,
//         upd_taken in; pc, pc4, npc, pred_taken, pred_target out
module pc_gen_btb #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              BTB_ENTRIES = 16,
  parameter bit              BTB_EN      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  pc_gen_btb_if.slave  bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] npc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  // Wraps naturally at 2^XLEN.
  assign pc4 = pc_q + XLEN'(4);

  always_comb begin
    npc = pc4;
    if (rst)
      npc = RESET_PC;
    else if (bus.redirect_valid)
      npc = {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (bus.stall)
      npc = pc_q;
    else if (pred_taken)
      npc = pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc_q <= RESET_PC;
    else
      pc_q <= npc;
  end

  // Redirect targets are forced word-aligned, so the low bits never matter.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  generate
    if (BTB_EN) begin : g_btb
      logic [BTB_ENTRIES-1:0] valid;
      logic [1:0]             ctr    [BTB_ENTRIES];
      logic [TAG_W-1:0]       tag    [BTB_ENTRIES];
      logic [XLEN-1:0]        target [BTB_ENTRIES];

      logic [IDX_W-1:0] rd_idx;
      logic [IDX_W-1:0] wr_idx;
      logic [TAG_W-1:0] rd_tag;
      logic [TAG_W-1:0] wr_tag;
      logic             rd_hit;
      logic             wr_hit;

      assign rd_idx = pc_q[IDX_W+1:2];
      assign rd_tag = pc_q[XLEN-1:IDX_W+2];
      assign wr_idx = bus.upd_pc[IDX_W+1:2];
      assign wr_tag = bus.upd_pc[XLEN-1:IDX_W+2];

      // Lookup reads the arrays before this edge's training write lands,
      // so a same-index update is only seen on the following cycle.
      assign rd_hit      = valid[rd_idx] && (tag[rd_idx] == rd_tag);
      assign wr_hit      = valid[wr_idx] && (tag[wr_idx] == wr_tag);
      assign pred_taken  = rd_hit && ctr[rd_idx][1];
      assign pred_target = target[rd_idx];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            ctr[i]    <= 2'b00;
            tag[i]    <= '0;
            target[i] <= '0;
          end
        end else if (bus.upd_valid) begin
          if (wr_hit) begin
            if (bus.upd_taken) begin
              if (ctr[wr_idx] != 2'b11)
                ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
              target[wr_idx] <= bus.upd_target;
            end else if (ctr[wr_idx] != 2'b00) begin
              ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
            end
          end else if (bus.upd_taken) begin
            // Allocate fresh entries as weak-taken, evicting any alias.
            valid[wr_idx]  <= 1'b1;
            tag[wr_idx]    <= wr_tag;
            target[wr_idx] <= bus.upd_target;
            ctr[wr_idx]    <= 2'b10;
          end
        end
      end

      logic unused_upd_lsb;
      assign unused_upd_lsb = ^bus.upd_pc[1:0];
    end else begin : g_no_btb
      assign pred_taken  = 1'b0;
      assign pred_target = '0;

      logic unused_upd;
      assign unused_upd = ^{bus.upd_valid, bus.upd_pc, bus.upd_target, bus.upd_taken};
    end
  endgenerate

  assign bus.pc          = pc_q;
  assign bus.pc4         = pc4;
  assign bus.npc         = npc;
  assign bus.pred_taken  = pred_taken;
  assign bus.pred_target = pred_target;
endmodule

// File: tb/tb_pc_gen_btb.sv
// tb/tb_pc_gen_btb.sv - directed self-checking bench for pc_gen_btb
module tb_pc_gen_btb;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_gen_btb_if #(.XLEN(32)) bus ();

  pc_gen_btb #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .BTB_ENTRIES(16), .BTB_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] addr);
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = addr;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
    n_checks++; if (bus.pc4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=%h", bus.pc4, 32'h4); end
    n_checks++; if (bus.npc !== 32'h0) begin n_fail++; $display("FAIL reset_npc got=%h exp=%h", bus.npc, 32'h0); end
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got=%b exp=0", bus.pred_taken); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.npc !== 32'h4) begin n_fail++; $display("FAIL seq_npc got=%h exp=%h", bus.npc, 32'h4); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (bus.pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc step=%0d got=%h exp=%h", i, bus.pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_stall_redirect;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, bus.pc, 32'h10); end
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
    #1;
    n_checks++; if (bus.npc !== 32'h200) begin n_fail++; $display("FAIL redirect_npc got=%h exp=%h", bus.npc, 32'h200); end
    tick();
    n_checks++; if (bus.pc !== 32'h200) begin n_fail++; $display("FAIL redirect_pc got=%h exp=%h", bus.pc, 32'h200); end
    idle_inputs();
  endtask

  task automatic test_allocate_predict;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h40; bus.upd_target = 32'h100; bus.upd_taken = 1'b1;
    do_redirect(32'h40);
    bus.upd_valid = 1'b0; bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred got=%b exp=1", bus.pred_taken); end
    n_checks++; if (bus.pred_target !== 32'h100) begin n_fail++; $display("FAIL alloc_target got=%h exp=%h", bus.pred_target, 32'h100); end
    n_checks++; if (bus.npc !== 32'h100) begin n_fail++; $display("FAIL alloc_npc got=%h exp=%h", bus.npc, 32'h100); end
    bus.stall = 1'b1; bus.upd_valid = 1'b1; bus.upd_taken = 1'b0;
    tick();
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt1_pred got=%b exp=0", bus.pred_taken); end
    n_checks++; if (bus.pc !== 32'h40) begin n_fail++; $display("FAIL nt1_pc got=%h exp=%h", bus.pc, 32'h40); end
    tick();
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt2_pred got=%b exp=0", bus.pred_taken); end
    bus.upd_valid = 1'b0; bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.npc !== 32'h44) begin n_fail++; $display("FAIL nt2_npc got=%h exp=%h", bus.npc, 32'h44); end
  endtask

  task automatic test_alias;
    do_redirect(32'h80);
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_miss got=%b exp=0", bus.pred_taken); end
    bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.npc !== 32'h84) begin n_fail++; $display("FAIL alias_npc got=%h exp=%h", bus.npc, 32'h84); end
    bus.stall = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h80; bus.upd_target = 32'h300; bus.upd_taken = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL replace_pred got=%b exp=1", bus.pred_taken); end
    n_checks++; if (bus.pred_target !== 32'h300) begin n_fail++; $display("FAIL replace_target got=%h exp=%h", bus.pred_target, 32'h300); end
    bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.npc !== 32'h300) begin n_fail++; $display("FAIL replace_npc got=%h exp=%h", bus.npc, 32'h300); end
    do_redirect(32'h40);
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL evicted_pred got=%b exp=0", bus.pred_taken); end
    bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.npc !== 32'h44) begin n_fail++; $display("FAIL evicted_npc got=%h exp=%h", bus.npc, 32'h44); end
  endtask

  task automatic test_saturation_bypass;
    bus.stall = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h40; bus.upd_target = 32'h100; bus.upd_taken = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_pred got=%b exp=1", bus.pred_taken); end
    // Same-cycle retarget: the lookup must still see the old target.
    bus.upd_target = 32'h180; bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.pred_target !== 32'h100) begin n_fail++; $display("FAIL bypass_old_target got=%h exp=%h", bus.pred_target, 32'h100); end
    n_checks++; if (bus.npc !== 32'h100) begin n_fail++; $display("FAIL bypass_old_npc got=%h exp=%h", bus.npc, 32'h100); end
    tick();
    bus.upd_valid = 1'b0;
    n_checks++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL bypass_pc got=%h exp=%h", bus.pc, 32'h100); end
    do_redirect(32'h40);
    n_checks++; if (bus.pred_target !== 32'h180) begin n_fail++; $display("FAIL bypass_new_target got=%h exp=%h", bus.pred_target, 32'h180); end
    n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL bypass_new_pred got=%b exp=1", bus.pred_taken); end
    // Counter at 11: one not-taken keeps it taken (10), the second drops it (01).
    bus.upd_valid = 1'b1; bus.upd_taken = 1'b0;
    tick();
    n_checks++; if (bus.pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_dec1 got=%b exp=1", bus.pred_taken); end
    tick();
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_dec2 got=%b exp=0", bus.pred_taken); end
    bus.upd_valid = 1'b0;
  endtask

  task automatic test_wrap_reset;
    do_redirect(32'hFFFF_FFFC);
    bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 32'hFFFF_FFFC); end
    n_checks++; if (bus.pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=%h", bus.pc4, 32'h0); end
    n_checks++; if (bus.npc !== 32'h0) begin n_fail++; $display("FAIL wrap_npc got=%h exp=%h", bus.npc, 32'h0); end
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next got=%h exp=%h", bus.pc, 32'h0); end
    // Entry at 0x40 is weak-NT; a taken update would make it predict taken unless discarded.
    rst = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h40; bus.upd_target = 32'h100; bus.upd_taken = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=%h", bus.pc, 32'h0); end
    rst = 1'b0; bus.upd_valid = 1'b0;
    do_redirect(32'h40);
    n_checks++; if (bus.pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_btb_clear got=%b exp=0", bus.pred_taken); end
    bus.stall = 1'b0;
    #1;
    n_checks++; if (bus.npc !== 32'h44) begin n_fail++; $display("FAIL rst_npc got=%h exp=%h", bus.npc, 32'h44); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_stall_redirect();
    test_allocate_predict();
    test_alias();
    test_saturation_bypass();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
